// File: rtl/nibble_rx_display_pkg.sv
// Shared types and constants for the serial-nibble receiver and its
// 7-segment decode.
package nibble_rx_pkg;

  localparam int SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_e;

  // Entry [n] is the segment pattern g..a for hex digit n.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/nibble_rx_display_if.sv
// Standard 8-in/8-out user-tile pin bundle.
interface nibble_rx_display_if;
  logic [7:0] io_in;
  logic [7:0] io_out;

  modport master (output io_in, input io_out);
  modport slave  (input io_in, output io_out);
endinterface

// File: rtl/nibble_rx_display_sync_rise.sv
// Multi-stage input synchroniser with an optional rising-edge pulse taken
// from one extra register behind the last stage.
module sync_rise #(
  parameter int STAGES  = 2,
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

  if (EDGE_EN) begin : g_edge
    logic dly_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) dly_q <= 1'b0;
      else       dly_q <= q_o;
    end
    assign rise_o = q_o & ~dly_q;
  end else begin : g_no_edge
    assign rise_o = 1'b0;
  end

endmodule

// File: rtl/nibble_rx_display.sv
// Receives a framed 4-bit serial nibble, shows it as a hex digit on a
// 7-segment display, and flags malformed frames on the decimal point.
module nibble_rx_display
  import nibble_rx_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  nibble_rx_display_if.slave tile
);

  logic [3:0] lvl_raw, lvl_s, unused_rise;
  logic       sdata_s, frame_s, lsb_s, hold_s, strobe_rise;
  logic       unused_strobe_lvl, unused_pins;

  // Level inputs: bit 0 sdata, 1 frame, 2 lsb_first, 3 hold.
  assign lvl_raw = {tile.io_in[6:4], tile.io_in[2]};

  for (genvar i = 0; i < 4; i++) begin : g_sync_lvl
    sync_rise #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .d_i    (lvl_raw[i]),
      .q_o    (lvl_s[i]),
      .rise_o (unused_rise[i])
    );
  end

  sync_rise #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_strobe (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (tile.io_in[3]),
    .q_o    (unused_strobe_lvl),
    .rise_o (strobe_rise)
  );

  assign sdata_s = lvl_s[0];
  assign frame_s = lvl_s[1];
  assign lsb_s   = lvl_s[2];
  assign hold_s  = lvl_s[3];

  // Clock and reset arrive on dedicated ports; pin 7 is spare.
  assign unused_pins = ^{tile.io_in[7], tile.io_in[1:0]};

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] shift_q, shift_d;
  logic [3:0] disp_q, disp_d;
  logic       err_q, err_d;
  logic [3:0] nib;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      disp_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      disp_q  <= disp_d;
      err_q   <= err_d;
    end
  end

  assign nib = lsb_s ? {sdata_s, shift_q[3:1]} : {shift_q[2:0], sdata_s};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    disp_d  = disp_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (frame_s) begin
          state_d = RECV;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      RECV: begin
        // A falling frame takes priority over a strobe in the same cycle.
        if (!frame_s) begin
          if (cnt_q != 2'd0) err_d = 1'b1;
          state_d = IDLE;
        end else if (strobe_rise) begin
          shift_d = nib;
          if (cnt_q == 2'd3) begin
            if (!hold_s) disp_d = nib;
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      DONE: begin
        if (!frame_s)         state_d = IDLE;
        else if (strobe_rise) err_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tile.io_out = {err_q, SEG_LUT[disp_q]};

endmodule

// File: tb/tb_nibble_rx_display.sv
// Self-checking bench: directed frame table, hand-timed corner cases and
// randomized frames against a frame-level reference model.
module tb_nibble_rx_display;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sdata = 1'b0, sstrobe = 1'b0, frame = 1'b0, lsb = 1'b0, hold = 1'b0;

  int compare_cnt  = 0;
  int mismatch_cnt = 0;

  nibble_rx_display_if bus ();

  always #5 clk = ~clk;

  always_comb bus.io_in = {1'b0, hold, lsb, frame, sstrobe, sdata, rst, clk};

  nibble_rx_display dut (
    .clk_i (clk),
    .rst_i (rst),
    .tile  (bus)
  );

  logic [6:0] seg_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    bit       lsb;
    bit       hold;
    int       nbits;
    bit [7:0] bits;   // bits[i] is the i-th bit sent
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [7];

  int m_disp;
  bit m_err;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [7:0] exp);
    compare_cnt++;
    if (bus.io_out !== exp) begin
      mismatch_cnt++;
      $display("FAIL %s: io_out=%02h expected=%02h at %0t", name, bus.io_out, exp, $time);
    end
  endtask

  task automatic send_bit(input bit b);
    sdata = b;
    cyc(3);
    sstrobe = 1'b1;
    cyc(3);
    sstrobe = 1'b0;
    cyc(3);
  endtask

  task automatic send_frame(input bit l, input bit h, input int n, input bit [7:0] bits);
    lsb  = l;
    hold = h;
    frame = 1'b1;
    cyc(4);
    for (int i = 0; i < n; i++) send_bit(bits[i]);
    frame = 1'b0;
    cyc(4);
  endtask

  // Frame-level reference: the first four bits form the nibble, fewer is a
  // short frame, more is an overrun.
  task automatic model_frame(input bit l, input bit h, input int n, input bit [7:0] bits);
    int val;
    val = 0;
    if (n == 0) return;
    if (n < 4) begin
      m_err = 1'b1;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      if (l) val = val + (int'(bits[i]) << i);
      else   val = val * 2 + int'(bits[i]);
    end
    if (!h) m_disp = val;
    m_err = (n > 4);
  endtask

  initial begin
    vecs[0] = '{lsb: 1'b0, hold: 1'b0, nbits: 4, bits: 8'b0000_0101, exp: 8'h77};
    vecs[1] = '{lsb: 1'b1, hold: 1'b0, nbits: 4, bits: 8'b0000_0011, exp: 8'h4F};
    vecs[2] = '{lsb: 1'b0, hold: 1'b0, nbits: 2, bits: 8'b0000_0001, exp: 8'hCF};
    vecs[3] = '{lsb: 1'b0, hold: 1'b0, nbits: 4, bits: 8'b0000_1111, exp: 8'h71};
    vecs[4] = '{lsb: 1'b0, hold: 1'b0, nbits: 5, bits: 8'b0001_0110, exp: 8'hFD};
    vecs[5] = '{lsb: 1'b0, hold: 1'b1, nbits: 4, bits: 8'b0000_0001, exp: 8'h7D};
    vecs[6] = '{lsb: 1'b1, hold: 1'b0, nbits: 0, bits: 8'b0000_0000, exp: 8'h7D};

    rst = 1'b1;
    cyc(2);
    check("reset", 8'h3F);
    rst = 1'b0;
    cyc(2);
    check("after_reset", 8'h3F);

    for (int i = 0; i < 12; i++) begin
      sdata   = i[0];
      sstrobe = i[1];
      lsb     = i[2];
      cyc(2);
    end
    sstrobe = 1'b0;
    cyc(4);
    check("idle_toggle", 8'h3F);

    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].lsb, vecs[i].hold, vecs[i].nbits, vecs[i].bits);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end
    hold = 1'b0;

    // Reset mid-frame: partial nibble dropped, no error.
    lsb = 1'b0;
    frame = 1'b1;
    cyc(4);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    frame = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(4);
    check("reset_mid_frame", 8'h3F);

    // Fresh frame 1,0,0,0 with the final strobe timed edge by edge.
    frame = 1'b1;
    cyc(4);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    sdata = 1'b0;
    cyc(3);
    sstrobe = 1'b1;
    cyc(1);
    check("lat_edge_k", 8'h3F);
    cyc(1);
    check("lat_edge_k1", 8'h3F);
    cyc(1);
    check("lat_edge_k2", 8'h7F);
    sstrobe = 1'b0;
    cyc(3);
    frame = 1'b0;
    cyc(4);
    check("fresh_frame", 8'h7F);

    // Frame drop coincident with a strobe: the 4th bit must not load.
    frame = 1'b1;
    cyc(4);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    sdata = 1'b1;
    cyc(3);
    sstrobe = 1'b1;
    frame   = 1'b0;
    cyc(4);
    sstrobe = 1'b0;
    cyc(4);
    check("frame_fall_vs_strobe", 8'hFF);

    m_disp = 8;
    m_err  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bit       l, h;
      int       n;
      bit [7:0] bits;
      l    = 1'($urandom_range(0, 1));
      h    = ($urandom_range(0, 3) == 0);
      n    = int'($urandom_range(0, 6));
      bits = 8'($urandom);
      send_frame(l, h, n, bits);
      model_frame(l, h, n, bits);
      check($sformatf("rand%0d", i), {m_err, seg_ref[m_disp]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

endmodule

// File: doc/nibble_rx_display.md
# nibble_rx_display

Downstream consumer for the counter/serializer tile: receives a 4-bit serial nibble framed by a frame-enable line and a bit strobe, and shows it as a hex digit on a 7-segment display. All inputs are asynchronous to the clock, so they are synchronised, edge-detected and framed by a small FSM. A sticky decimal-point flag reports malformed frames. Packaged as a standard 8-in/8-out user tile.

## Interface
- SYNC_STAGES, 2: flip-flop stages per input synchroniser (≥2).
- io_in[0]  input  1  clk; the only clock, all state on its rising edge.
- io_in[1]  input  1  rst; synchronous, active-high.
- io_in[2]  input  1  sdata; serial data bit.
- io_in[3]  input  1  sstrobe; bit strobe, data taken on its rising edge.
- io_in[4]  input  1  frame; high = frame active, low = idle/abort.
- io_in[5]  input  1  lsb_first; 0 = MSB first, 1 = LSB first. Sampled at each shift.
- io_in[6]  input  1  hold; 1 freezes the displayed digit.
- io_in[7]  input  1  unused, ignored.
- io_out[6:0]  output  7  segments g..a (io_out[0]=a), active-high.
- io_out[7]  output  1  dp; sticky frame-error flag.

## Operation
- Inputs io_in[2..6] each pass through a SYNC_STAGES synchroniser. sstrobe gets one extra register; strobe_rise = sync_out & ~delayed.
- FSM states: IDLE, RECV, DONE. The state, a 2-bit bit count, a 4-bit shift register, a 4-bit display register and the err flag are the only state besides the synchronisers.
- IDLE: stays while frame_s=0. On frame_s=1, go to RECV with count=0 and shift register cleared. strobe_rise is ignored in IDLE.
- RECV, strobe_rise with frame_s=1:
  - MSB-first shifts sdata_s in at bit 0 (shift left).
  - LSB-first shifts it in at bit 3 (shift right).
  - count increments.
  - On the 4th bit: the completed nibble loads into the display register unless hold_s=1; err clears (also when hold_s=1); go to DONE.
- RECV, frame_s=0:
  - count=0: return to IDLE, no error.
  - count 1..3: set err, return to IDLE, display unchanged.
- DONE: strobe_rise with frame_s=1 sets err (overrun); the bit is discarded and the display is unchanged. frame_s=0 returns to IDLE.
- Same-cycle frame_s falling and strobe_rise: frame_s=0 wins and the strobe is ignored.
- Segment decode is combinational from the display register. Values as io_out[6:0]:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- io_out[7] = err.

## Timing
- Reset (rst_s is not synchronised; io_in[1] is used directly):
  - All synchroniser stages cleared, FSM to IDLE, count/shift register cleared, display register 0, err 0.
  - io_out = 0x3F on the clock edge after rst is sampled high.
- Reset mid-frame discards the partial nibble and sets no error.
- Latency with SYNC_STAGES=2: an sstrobe rise sampled at edge k is detected after edge k+1 and acted on at edge k+2. The display and dp change after edge k+2, i.e. 3 edges from first sampling.
- sdata must be stable for ≥3 clk cycles before and ≥1 cycle after the sstrobe rise.
- sstrobe high and low phases must each be ≥2 clk cycles; narrower pulses may be missed.
- frame must rise ≥1 cycle before the first sstrobe rise, measured after synchronisation.
- The display register holds indefinitely between frames. Count never wraps; DONE absorbs extra strobes.

## Structure
- Shared package nibble_rx_pkg holds:
  - the state enum (IDLE, RECV, DONE);
  - the 16-entry 7-bit segment lookup constant;
  - the default SYNC_STAGES.
- One sub-module, sync_rise: a parameterised synchroniser with an optional rising-edge output. It is instantiated for sstrobe with the edge output used, and for sdata, frame, lsb_first and hold with the edge output unused.
- The top level contains the FSM, shift register, display register, err and decode.

## Test plan
- Assert rst for 2 cycles, then release → io_out=0x3F. Toggling inputs with frame=0 → io_out stays 0x3F.
- frame=1, lsb_first=0, bits 1,0,1,0 → 3 cycles after the 4th strobe rise io_out=0x77 ('A'), dp=0.
- lsb_first=1, bits 1,1,0,0 (nibble 0011) → io_out=0x4F.
- Short frame: 2 strobes then frame=0 → digit unchanged, io_out[7]=1. Then a good MSB-first frame 1,1,1,1 → io_out=0x71, dp cleared.
- Overrun: 5 strobes, MSB-first 0,1,1,0,1 → digit 6 (0x7D), dp=1 after the 5th strobe.
- Hold and reset:
  - hold=1 during a full frame 1,0,0,0 → display unchanged, dp=0.
  - rst after 2 bits of the next frame → io_out=0x3F.
  - A fresh frame 1,0,0,0 with hold=0 → io_out=0x7F.
